// File: rtl/soc_system_button_pio_if.sv
// Avalon-MM slave bus bundle for the button/switch input PIO.
// Port names match the original flat Avalon ports.
interface soc_system_button_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_button_pio.sv
// Parameterised Avalon-MM input PIO: per-bit synchroniser, debounce, edge capture
// with interrupt mask, and a registered level IRQ.
module soc_system_button_pio #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter int unsigned      EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] IRQ_MASK_RESET  = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    soc_system_button_pio_if.slave bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);
    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edgecapture_next;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] irqmask_next;
    logic [CW-1:0]    cnt [WIDTH];
    logic             wr;
    logic [31:0]      rd_next;

    assign wr = bus.chipselect && !bus.write_n;

    always_comb begin
        case (EDGE_TYPE)
            0:       ev = stable & ~stable_d;
            1:       ev = ~stable & stable_d;
            default: ev = stable ^ stable_d;
        endcase
    end

    // New edges are OR-ed in after the W1C mask so a same-cycle set beats the clear.
    always_comb begin
        irqmask_next     = irqmask;
        edgecapture_next = edgecapture | ev;
        if (wr && bus.address == 2'd2) begin
            irqmask_next = bus.writedata[WIDTH-1:0];
        end
        if (wr && bus.address == 2'd3) begin
            edgecapture_next = (edgecapture & ~bus.writedata[WIDTH-1:0]) | ev;
        end
    end

    always_comb begin
        rd_next = '0;
        case (bus.address)
            2'd0:    rd_next[WIDTH-1:0] = stable;
            2'd1:    rd_next[WIDTH-1:0] = sync2;
            2'd2:    rd_next[WIDTH-1:0] = irqmask;
            default: rd_next[WIDTH-1:0] = edgecapture;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1         <= '0;
            sync2         <= '0;
            stable        <= '0;
            stable_d      <= '0;
            edgecapture   <= '0;
            irqmask       <= IRQ_MASK_RESET;
            irq           <= 1'b0;
            bus.readdata  <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= in_port;
            sync2    <= sync1;
            stable_d <= stable;
            // Any return to the current stable level restarts the count from zero.
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            edgecapture  <= edgecapture_next;
            irqmask      <= irqmask_next;
            irq          <= |(edgecapture_next & irqmask_next);
            bus.readdata <= rd_next;
        end
    end
endmodule

// File: tb/tb_soc_system_button_pio.sv
// Scoreboard bench for soc_system_button_pio: rising/falling/any edge instances,
// debounce latency, glitch rejection, IRQ flow, W1C collision and mid-op reset.
module tb_soc_system_button_pio;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] address;
    logic       write_n;
    logic [31:0] writedata;
    logic       cs0, cs1, cs2;
    logic [3:0] in0, in12;
    logic       irq0, irq1, irq2;

    logic [31:0] sb[$];
    logic [31:0] exp;
    int          checks = 0;
    int          failures = 0;
    logic        saw_hi;

    soc_system_button_pio_if bus0 ();
    soc_system_button_pio_if bus1 ();
    soc_system_button_pio_if bus2 ();

    assign bus0.address = address;  assign bus0.write_n = write_n;
    assign bus0.writedata = writedata;  assign bus0.chipselect = cs0;
    assign bus1.address = address;  assign bus1.write_n = write_n;
    assign bus1.writedata = writedata;  assign bus1.chipselect = cs1;
    assign bus2.address = address;  assign bus2.write_n = write_n;
    assign bus2.writedata = writedata;  assign bus2.chipselect = cs2;

    soc_system_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_MASK_RESET(4'h0))
        u0 (.clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0), .irq(irq0));
    soc_system_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IRQ_MASK_RESET(4'h5))
        u1 (.clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in12), .irq(irq1));
    soc_system_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IRQ_MASK_RESET(4'hA))
        u2 (.clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in12), .irq(irq2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick();
    endtask

    task automatic wr(input logic [2:0] sel, input logic [1:0] a, input logic [31:0] d);
        {cs2, cs1, cs0} = sel;
        address = a; writedata = d; write_n = 1'b0;
        tick();
        {cs2, cs1, cs0} = 3'b000;
        write_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ticks(3);
        sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL rst_rd0 got=%h exp=%h", bus0.readdata, exp); end
        exp = sb.pop_front(); checks++;
        if (bus1.readdata !== exp) begin failures++; $display("FAIL rst_rd1 got=%h exp=%h", bus1.readdata, exp); end
        exp = sb.pop_front(); checks++;
        if (bus2.readdata !== exp) begin failures++; $display("FAIL rst_rd2 got=%h exp=%h", bus2.readdata, exp); end
        sb.push_back(32'h0);
        exp = sb.pop_front(); checks++;
        if ({29'b0, irq2, irq1, irq0} !== exp) begin failures++; $display("FAIL rst_irq got=%b%b%b exp=000", irq2, irq1, irq0); end
        reset_n = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h5); sb.push_back(32'hA);
        rd(2'd2);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL rst_mask0 got=%h exp=%h", bus0.readdata, exp); end
        exp = sb.pop_front(); checks++;
        if (bus1.readdata !== exp) begin failures++; $display("FAIL rst_mask1 got=%h exp=%h", bus1.readdata, exp); end
        exp = sb.pop_front(); checks++;
        if (bus2.readdata !== exp) begin failures++; $display("FAIL rst_mask2 got=%h exp=%h", bus2.readdata, exp); end
    endtask

    task automatic test_latency();
        in0 = 4'h1; address = 2'd1;
        sb.push_back(32'h0); sb.push_back(32'h1);
        ticks(2);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL raw_edge2 got=%h exp=%h", bus0.readdata, exp); end
        tick();
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL raw_edge3 got=%h exp=%h", bus0.readdata, exp); end
        address = 2'd0;
        sb.push_back(32'h0); sb.push_back(32'h1);
        ticks(3);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL data_edge6 got=%h exp=%h", bus0.readdata, exp); end
        tick();
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL data_edge7 got=%h exp=%h", bus0.readdata, exp); end
        sb.push_back(32'h1);
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL ec_latency got=%h exp=%h", bus0.readdata, exp); end
        wr(3'b001, 2'd3, 32'hF);
    endtask

    task automatic test_glitch();
        in0 = 4'h5; ticks(3); in0 = 4'h1; ticks(8);
        sb.push_back(32'h1);
        rd(2'd0);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL glitch_data got=%h exp=%h", bus0.readdata, exp); end
        sb.push_back(32'h0); sb.push_back(32'h0);
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL glitch_ec got=%h exp=%h", bus0.readdata, exp); end
        exp = sb.pop_front(); checks++;
        if ({31'b0, irq0} !== exp) begin failures++; $display("FAIL glitch_irq got=%b exp=0", irq0); end
        address = 2'd0;
        in0 = 4'h5; ticks(4); in0 = 4'h1;
        saw_hi = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus0.readdata[2]) saw_hi = 1'b1;
        end
        sb.push_back(32'h1); sb.push_back(32'h1);
        exp = sb.pop_front(); checks++;
        if ({31'b0, saw_hi} !== exp) begin failures++; $display("FAIL pulse_seen got=%b exp=1", saw_hi); end
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL pulse_back got=%h exp=%h", bus0.readdata, exp); end
        sb.push_back(32'h4);
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL pulse_ec got=%h exp=%h", bus0.readdata, exp); end
        wr(3'b001, 2'd3, 32'hF);
    endtask

    task automatic test_irq();
        wr(3'b001, 2'd2, 32'hFFFF_FFF4);
        sb.push_back(32'h4);
        rd(2'd2);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL mask_wr got=%h exp=%h", bus0.readdata, exp); end
        in0 = 4'h5;
        sb.push_back(32'h0); sb.push_back(32'h1);
        ticks(6);
        exp = sb.pop_front(); checks++;
        if ({31'b0, irq0} !== exp) begin failures++; $display("FAIL irq_early got=%b exp=%h", irq0, exp); end
        tick();
        exp = sb.pop_front(); checks++;
        if ({31'b0, irq0} !== exp) begin failures++; $display("FAIL irq_set got=%b exp=%h", irq0, exp); end
        wr(3'b001, 2'd3, 32'h0);
        sb.push_back(32'h1); sb.push_back(32'h4);
        exp = sb.pop_front(); checks++;
        if ({31'b0, irq0} !== exp) begin failures++; $display("FAIL irq_w0 got=%b exp=%h", irq0, exp); end
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL ec_w0 got=%h exp=%h", bus0.readdata, exp); end
        wr(3'b001, 2'd3, 32'h4);
        sb.push_back(32'h0); sb.push_back(32'h0);
        exp = sb.pop_front(); checks++;
        if ({31'b0, irq0} !== exp) begin failures++; $display("FAIL irq_clr got=%b exp=%h", irq0, exp); end
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL ec_clr got=%h exp=%h", bus0.readdata, exp); end
    endtask

    task automatic test_mask();
        wr(3'b001, 2'd2, 32'h0);
        in0 = 4'h0; ticks(10);
        wr(3'b001, 2'd3, 32'hF);
        in0 = 4'hF; ticks(10);
        sb.push_back(32'hF); sb.push_back(32'h0);
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL mask_ec got=%h exp=%h", bus0.readdata, exp); end
        exp = sb.pop_front(); checks++;
        if ({31'b0, irq0} !== exp) begin failures++; $display("FAIL masked_irq got=%b exp=%h", irq0, exp); end
        wr(3'b001, 2'd2, 32'hF);
        sb.push_back(32'h1);
        exp = sb.pop_front(); checks++;
        if ({31'b0, irq0} !== exp) begin failures++; $display("FAIL unmask_irq got=%b exp=%h", irq0, exp); end
    endtask

    task automatic test_edge_modes();
        in12 = 4'h1; ticks(10);
        sb.push_back(32'h0); sb.push_back(32'h1);
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus1.readdata !== exp) begin failures++; $display("FAIL fall_on_rise got=%h exp=%h", bus1.readdata, exp); end
        exp = sb.pop_front(); checks++;
        if (bus2.readdata !== exp) begin failures++; $display("FAIL any_on_rise got=%h exp=%h", bus2.readdata, exp); end
        wr(3'b110, 2'd3, 32'hF);
        in12 = 4'h0; ticks(10);
        sb.push_back(32'h1); sb.push_back(32'h1);
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus1.readdata !== exp) begin failures++; $display("FAIL fall_on_fall got=%h exp=%h", bus1.readdata, exp); end
        exp = sb.pop_front(); checks++;
        if (bus2.readdata !== exp) begin failures++; $display("FAIL any_on_fall got=%h exp=%h", bus2.readdata, exp); end
    endtask

    task automatic test_collision();
        in12 = 4'h1; ticks(6);
        wr(3'b100, 2'd3, 32'h1);
        sb.push_back(32'h1);
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus2.readdata !== exp) begin failures++; $display("FAIL set_wins got=%h exp=%h", bus2.readdata, exp); end
        wr(3'b100, 2'd3, 32'h1);
        sb.push_back(32'h0);
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus2.readdata !== exp) begin failures++; $display("FAIL w1c_quiet got=%h exp=%h", bus2.readdata, exp); end
    endtask

    task automatic test_reset_midop();
        in0 = 4'h0; ticks(3);
        #2 reset_n = 1'b0;
        #1;
        sb.push_back(32'h0); sb.push_back(32'h0);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL midrst_rd got=%h exp=%h", bus0.readdata, exp); end
        exp = sb.pop_front(); checks++;
        if ({31'b0, irq0} !== exp) begin failures++; $display("FAIL midrst_irq got=%b exp=%h", irq0, exp); end
        in0 = 4'hF;
        tick();
        reset_n = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h5);
        rd(2'd2);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL midrst_mask0 got=%h exp=%h", bus0.readdata, exp); end
        exp = sb.pop_front(); checks++;
        if (bus1.readdata !== exp) begin failures++; $display("FAIL midrst_mask1 got=%h exp=%h", bus1.readdata, exp); end
        sb.push_back(32'h0);
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL midrst_ec0 got=%h exp=%h", bus0.readdata, exp); end
        ticks(8);
        sb.push_back(32'hF);
        rd(2'd3);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL post_rst_ec got=%h exp=%h", bus0.readdata, exp); end
        sb.push_back(32'hF);
        rd(2'd0);
        exp = sb.pop_front(); checks++;
        if (bus0.readdata !== exp) begin failures++; $display("FAIL post_rst_data got=%h exp=%h", bus0.readdata, exp); end
    endtask

    initial begin
        reset_n = 1'b0;
        address = 2'd0; write_n = 1'b1; writedata = '0;
        cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
        in0 = 4'h0; in12 = 4'h0;
        test_reset();
        test_latency();
        test_glitch();
        test_irq();
        test_mask();
        test_edge_modes();
        test_collision();
        test_reset_midop();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
